// File: rtl/hc16x_counter.sv
// ---------------------------------------------------------------------------
// hc16x_counter
//   Parametrised '161/'163-style synchronous counter: configurable width,
//   programmable modulus, up/down direction, parallel load, cascadable
//   ripple-carry output (RCO) and a registered terminal-count pulse (TC_Q).
//
//   Build option:
//     HC_CNT_SCLR_EN  defined   -> nSCLR port exists, synchronous clear with
//                                  highest priority ('163 behaviour).
//     HC_CNT_SCLR_EN  undefined -> no nSCLR port; only sys_rst_n clears
//                                  ('161 behaviour).
// ---------------------------------------------------------------------------
module hc16x_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 2**WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
`ifdef HC_CNT_SCLR_EN
    input  logic             nSCLR,
`endif
    input  logic             nLOAD,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             UP,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC_Q
);

    // -----------------------------------------------------------------------
    // Parameter legality: bad configurations stop elaboration outright.
    // -----------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("hc16x_counter: WIDTH must be within 1..16");
    end

    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("hc16x_counter: MODULUS must be within 2..2**WIDTH");
    end

    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("hc16x_counter: RESET_VAL must be below MODULUS");
    end

    // Highest count state and the reset image, both at the counter width.
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // -----------------------------------------------------------------------
    // Request decoding
    // -----------------------------------------------------------------------
    logic             sclr_req;    // synchronous clear requested this edge
    logic             load_req;    // parallel load requested this edge
    logic             count_en;    // both count enables asserted
    logic             at_top;      // Q sits on MODULUS-1
    logic             at_bottom;   // Q sits on zero
    logic             term;        // terminal state for the current direction
    logic [WIDTH-1:0] step_up;     // successor when counting up
    logic [WIDTH-1:0] step_dn;     // successor when counting down
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;

`ifdef HC_CNT_SCLR_EN
    assign sclr_req = ~nSCLR;
`else
    assign sclr_req = 1'b0;
`endif

    assign load_req  = ~nLOAD;
    assign count_en  = ENT & ENP;
    assign at_top    = (Q == LAST);
    assign at_bottom = (Q == '0);

    // The terminal state depends on direction only; an out-of-range Q is
    // never terminal, so it never raises RCO or TC_Q.
    assign term = UP ? at_top : at_bottom;

    // Counting up: anything at or beyond the last state wraps to zero, which
    // also pulls an out-of-range loaded value back into the count range.
    assign step_up = (Q >= LAST) ? '0 : Q + ONE;

    // Counting down: zero wraps to the last state; an out-of-range value
    // simply decrements until it re-enters the range.
    assign step_dn = at_bottom ? LAST : Q - ONE;

    // Ripple carry is combinational so a following stage sees it in the same
    // cycle through its ENT input; ENP and nLOAD deliberately do not gate it.
    assign RCO = ENT & term;

    // -----------------------------------------------------------------------
    // Next-state selection: clear > load > count > hold.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch so
        // no path leaves a variable unassigned, which would infer a latch.
        q_nxt  = Q;
        tc_nxt = 1'b0;
        if (sclr_req) begin
            q_nxt = '0;
        end else if (load_req) begin
            q_nxt = DATA;
        end else if (count_en) begin
            q_nxt  = UP ? step_up : step_dn;
            tc_nxt = term;
        end
    end

    // -----------------------------------------------------------------------
    // State register with asynchronous reset to RESET_VAL.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!sys_rst_n) begin
            Q    <= RST_Q;
            TC_Q <= 1'b0;
        end else begin
            Q    <= q_nxt;
            TC_Q <= tc_nxt;
        end
    end

endmodule
